// File: rtl/emmc_bist_seq_pkg.sv
// Shared types and constants for the eMMC BIST sequencer: FSM states and the PRBS16 definition.
package emmc_bist_p;

  typedef enum logic [2:0] {
    StIdle,
    StWrStart,
    StWrData,
    StWrWait,
    StRdStart,
    StRdData,
    StRdWait,
    StFin
  } state_e;

  // x^16+x^14+x^13+x^11+1 in right-shift Fibonacci form: feedback from bits 0, 2, 3 and 5.
  localparam logic [15:0] Prbs16Taps  = 16'h002D;
  localparam logic [15:0] DefaultSeed = 16'hACE1;

endpackage

// File: rtl/prbs16.sv
// PRBS16 Fibonacci LFSR with synchronous load and advance; bit_o is the current bit 0.
module prbs16
  import emmc_bist_p::*;
#(
  parameter logic [15:0] SEED = DefaultSeed
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic load_i,
  input  logic adv_i,
  output logic bit_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (adv_i) begin
      lfsr_d = {^(lfsr_q & Prbs16Taps), lfsr_q[15:1]};
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign bit_o = lfsr_q[0];

endmodule

// File: rtl/emmc_bist_seq.sv
// eMMC BIST sequencer: writes a PRBS16 pattern, reads it back and checks it, with a watchdog.
// Optional mismatch counter port err_cnt_o is built when EMMC_BIST_ERR_CNT_EN is defined.
module emmc_bist_seq
  import emmc_bist_p::*;
#(
  parameter int unsigned BLK_CNT  = 2,
  parameter int unsigned BLK_BITS = 4096,
  parameter logic [15:0] SEED     = DefaultSeed,
  parameter int unsigned TIMEOUT  = 1048576
) (
  input  logic        clk_i,
  input  logic        arst_i,
  input  logic        go_i,
  output logic        we_o,
  output logic        start_o,
  output logic [15:0] blk_cnt_o,
  output logic        dat_o,
  input  logic        dat_i,
  input  logic        dvalid_i,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
`ifdef EMMC_BIST_ERR_CNT_EN
  output logic        timeout_o,
  output logic [15:0] err_cnt_o
`else
  output logic        timeout_o
`endif
);

  localparam int unsigned TotalBits = BLK_CNT * BLK_BITS;
  localparam int unsigned BitW      = $clog2(TotalBits + 1);
  localparam int unsigned WdW       = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d, state_nom;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WdW-1:0]   wd_q, wd_d;
  logic             mis_q, mis_d;
  logic             pass_q, pass_d;
  logic             to_q, to_d;
  logic             strobe, last_bit, progress, wd_expire, prbs_load, prbs_bit, go_idle;

  prbs16 #(
    .SEED (SEED)
  ) u_prbs (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .load_i (prbs_load),
    .adv_i  (strobe),
    .bit_o  (prbs_bit)
  );

  assign last_bit = (bit_cnt_q == BitW'(TotalBits - 1));
  assign go_idle  = (state_q == StIdle) && go_i;

  always_comb begin
    state_nom = state_q;
    start_o   = 1'b0;
    strobe    = 1'b0;
    unique case (state_q)
      StIdle:    if (go_i) state_nom = StWrStart;
      StWrStart: if (ready_i) begin
        start_o   = 1'b1;
        state_nom = StWrData;
      end
      StWrData:  if (dvalid_i) begin
        strobe = 1'b1;
        if (last_bit) state_nom = StWrWait;
      end
      StWrWait:  if (ready_i) state_nom = StRdStart;
      StRdStart: if (ready_i) begin
        start_o   = 1'b1;
        state_nom = StRdData;
      end
      StRdData:  if (dvalid_i) begin
        strobe = 1'b1;
        if (last_bit) state_nom = StRdWait;
      end
      StRdWait:  if (ready_i) state_nom = StFin;
      StFin:     state_nom = StIdle;
      default:   state_nom = StIdle;
    endcase

    // Watchdog is judged against the nominal next state so it never feeds back on itself.
    progress  = strobe || (state_nom != state_q);
    wd_expire = (state_q != StIdle) && !progress && (wd_q == WdW'(TIMEOUT - 1));
    state_d   = wd_expire ? StFin : state_nom;

    if (state_d == StIdle) begin
      wd_d = '0;
    end else if (progress) begin
      wd_d = WdW'(1);
    end else begin
      wd_d = wd_q + WdW'(1);
    end

    if (strobe) begin
      bit_cnt_d = last_bit ? '0 : bit_cnt_q + BitW'(1);
    end else if (state_q == StWrData || state_q == StRdData) begin
      bit_cnt_d = bit_cnt_q;
    end else begin
      bit_cnt_d = '0;
    end

    prbs_load = (state_d == StWrStart || state_d == StRdStart) && (state_d != state_q);

    mis_d = mis_q;
    if (go_idle) begin
      mis_d = 1'b0;
    end else if (state_q == StRdData && dvalid_i && (dat_i != prbs_bit)) begin
      mis_d = 1'b1;
    end

    to_d   = to_q;
    pass_d = pass_q;
    if (go_idle) to_d = 1'b0;
    if (wd_expire) begin
      to_d   = 1'b1;
      pass_d = 1'b0;
    end
    if (state_q == StFin) pass_d = !mis_q && !to_q;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      wd_q      <= '0;
      mis_q     <= 1'b0;
      pass_q    <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      wd_q      <= wd_d;
      mis_q     <= mis_d;
      pass_q    <= pass_d;
      to_q      <= to_d;
    end
  end

`ifdef EMMC_BIST_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (go_idle) begin
      err_cnt_d = '0;
    end else if (state_q == StRdData && dvalid_i && (dat_i != prbs_bit) &&
                 (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

  assign we_o      = (state_q == StWrStart) || (state_q == StWrData) || (state_q == StWrWait);
  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StFin);
  assign pass_o    = pass_q;
  assign timeout_o = to_q;
  assign dat_o     = prbs_bit;
  assign blk_cnt_o = 16'(BLK_CNT);

endmodule

// File: tb/tb_emmc_bist_seq.sv
// Self-checking bench for emmc_bist_seq: an eMMC loopback model plus a phase-level reference model.
`timescale 1ns/1ps
module tb_emmc_bist_seq;

  localparam int Total   = 8192;
  localparam int Timeout = 1000;

  logic clk = 1'b0, arst = 1'b1, go = 1'b0, ready = 1'b1, dvalid = 1'b0, dat_in = 1'b0;
  logic we, start, dat_out, busy, done, pass, tmo;
  logic [15:0] blk_cnt;
`ifdef EMMC_BIST_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  emmc_bist_seq #(
    .BLK_CNT  (2),
    .BLK_BITS (4096),
    .SEED     (16'hACE1),
    .TIMEOUT  (Timeout)
  ) dut (
    .clk_i     (clk),
    .arst_i    (arst),
    .go_i      (go),
    .we_o      (we),
    .start_o   (start),
    .blk_cnt_o (blk_cnt),
    .dat_o     (dat_out),
    .dat_i     (dat_in),
    .dvalid_i  (dvalid),
    .ready_i   (ready),
    .busy_o    (busy),
    .done_o    (done),
    .pass_o    (pass),
`ifdef EMMC_BIST_ERR_CNT_EN
    .timeout_o (tmo),
    .err_cnt_o (err_cnt)
`else
    .timeout_o (tmo)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference PRBS sequence from the polynomial definition.
  logic exp_bits [Total];
  logic wmem [Total];

  // eMMC loopback model configuration.
  bit cfg_full = 1'b1, cfg_ready_block = 1'b0, sm_clear = 1'b0;
  int cfg_stall_after = 0, cfg_flip_a = -1, cfg_flip_b = -1;

  initial begin : emmc_model
    logic s_start, s_we, s_dat, s_dv;
    bit   sm_xfer, sm_dir;
    int   sm_idx, sm_pb, sm_cnt;
    sm_xfer = 0; sm_dir = 0; sm_idx = 0; sm_pb = 0; sm_cnt = 0;
    forever begin
      @(negedge clk);
      s_start = start; s_we = we; s_dat = dat_out; s_dv = dvalid;
      @(posedge clk);
      #1;
      if (arst || sm_clear) begin
        sm_xfer = 0; sm_pb = 0; sm_cnt = 0; sm_idx = 0;
      end else begin
        if (sm_xfer && s_dv) begin
          if (sm_dir) wmem[sm_idx] = s_dat;
          sm_idx++;
          sm_cnt++;
          if (sm_idx == Total) begin
            sm_xfer = 0;
            sm_pb   = $urandom_range(0, 3);
          end
        end
        if (s_start) begin
          sm_xfer = 1; sm_dir = s_we; sm_idx = 0;
        end
        if (sm_pb > 0) sm_pb--;
      end
      ready  = !sm_xfer && (sm_pb == 0) && !cfg_ready_block;
      dvalid = sm_xfer && !(cfg_stall_after > 0 && sm_cnt >= cfg_stall_after) &&
               (cfg_full || $urandom_range(0, 7) != 0);
      if (sm_xfer && !sm_dir)
        dat_in = wmem[sm_idx] ^ ((sm_idx == cfg_flip_a) || (sm_idx == cfg_flip_b));
      else
        dat_in = 1'($urandom);
    end
  end

  // Phase model: 0 idle, 1 write, 2 write done, 3 read, 4 read done, 5 finish.
  int  mph = 0, wcnt = 0, rcnt = 0, nop = 0, m_err = 0;
  int  done_cnt = 0, start_cnt = 0, cyc = 0, last_strobe_cyc = 0, done_cyc = 0;
  bit  started = 0, m_mis = 0, m_to = 0, m_pass = 0;

  always @(negedge clk) begin : compare
    logic exp_start, strobe;
    int   nxt;
    cyc++;
    if (arst) begin
      check("reset_outputs", {busy, we, start, done, pass, tmo}, 6'b0);
`ifdef EMMC_BIST_ERR_CNT_EN
      check("reset_err_cnt", err_cnt, 0);
`endif
      mph = 0; m_mis = 0; m_to = 0; m_pass = 0; m_err = 0; nop = 0; started = 0;
    end else begin
      exp_start = (mph == 1 || mph == 3) && !started && ready;
      strobe    = dvalid && started && (mph == 1 || mph == 3);
      check("busy", busy, mph != 0);
      check("done", done, mph == 5);
      check("we", we, mph == 1 || mph == 2);
      check("start", start, exp_start);
      check("pass", pass, m_pass);
      check("timeout", tmo, m_to);
      check("blk_cnt", blk_cnt, 2);
`ifdef EMMC_BIST_ERR_CNT_EN
      check("err_cnt", err_cnt, m_err);
`endif
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (start) start_cnt++;
      if (strobe) last_strobe_cyc = cyc;
      nxt = mph;
      case (mph)
        0: if (go) begin
          nxt = 1; m_to = 0; m_mis = 0; m_err = 0; wcnt = 0; rcnt = 0; started = 0;
        end
        1: begin
          if (exp_start) started = 1;
          if (strobe) begin
            check("write_bit", dat_out, exp_bits[wcnt]);
            wcnt++;
            if (wcnt == Total) nxt = 2;
          end
        end
        2: if (ready) begin nxt = 3; started = 0; end
        3: begin
          if (exp_start) started = 1;
          if (strobe) begin
            if (dat_in !== exp_bits[rcnt]) begin
              m_mis = 1;
              if (m_err < 65535) m_err++;
            end
            rcnt++;
            if (rcnt == Total) nxt = 4;
          end
        end
        4: if (ready) nxt = 5;
        5: begin nxt = 0; m_pass = !m_mis && !m_to; end
        default: nxt = 0;
      endcase
      if (mph == 0 || strobe || exp_start || nxt != mph) nop = 0;
      else nop++;
      if (mph >= 1 && mph <= 4 && nop == Timeout - 1) begin
        nxt = 5; m_to = 1; m_pass = 0;
      end
      mph = nxt;
    end
  end

  task automatic launch(input int hold);
    @(posedge clk); #2;
    sm_clear = 1; go = 1; cfg_ready_block = (hold > 0);
    @(posedge clk); #2;
    sm_clear = 0; go = 0;
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #2 cfg_ready_block = 0;
    end
  endtask

  task automatic wait_done(input int d0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin @(posedge clk); n++; end
    check("run_completes", done_cnt != d0, 1);
    repeat (4) @(posedge clk);
    #2;
  endtask

  initial begin : main
    int s, fb, d0, s0, n;
    logic [15:0] head;
    s = 16'hACE1;
    for (int i = 0; i < Total; i++) begin
      exp_bits[i] = 1'(s & 1);
      fb = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 1;
      s  = (s >> 1) | (fb << 15);
    end
    for (int i = 0; i < 16; i++) head[i] = exp_bits[i];
    check("model_head", head, 16'hACE1);
    check("model_bit16", exp_bits[16], 0);
    check("model_bit17", exp_bits[17], 1);

    repeat (3) @(posedge clk);
    #2 arst = 0;
    @(posedge clk); #2;
    check("post_reset_idle", {busy, pass, tmo, done}, 4'b0);

    // Full loopback with continuous strobes.
    d0 = done_cnt;
    launch(0);
    wait_done(d0, 20000);
    check("a_wr_strobes", wcnt, Total);
    check("a_rd_strobes", rcnt, Total);
    check("a_done_once", done_cnt - d0, 1);
    check("a_pass", pass, 1);
`ifdef EMMC_BIST_ERR_CNT_EN
    check("a_err_cnt", err_cnt, 0);
`endif

    // Random strobes, two flipped read bits, ready held off, and an ignored go mid-run.
    cfg_full = 0; cfg_flip_a = 100; cfg_flip_b = 5000;
    d0 = done_cnt; s0 = start_cnt;
    launch(50);
    repeat (200) @(posedge clk);
    #2 go = 1;
    @(posedge clk); #2 go = 0;
    wait_done(d0, 30000);
    check("b_starts", start_cnt - s0, 2);
    check("b_done_once", done_cnt - d0, 1);
    check("b_pass", pass, 0);
    check("b_timeout", tmo, 0);
`ifdef EMMC_BIST_ERR_CNT_EN
    check("b_err_cnt", err_cnt, 2);
`endif
    cfg_flip_a = -1; cfg_flip_b = -1;

    // Stall after 10 write bits: watchdog ends the run.
    cfg_full = 1; cfg_stall_after = 10;
    d0 = done_cnt;
    launch(0);
    wait_done(d0, 3000);
    check("d_wr_strobes", wcnt, 10);
    check("d_timeout", tmo, 1);
    check("d_pass", pass, 0);
    check("d_done_gap", done_cyc - last_strobe_cyc, Timeout);
    cfg_stall_after = 0;

    // Reset during read bit 3000, then a full clean run.
    d0 = done_cnt;
    launch(0);
    n = 0;
    while (!(mph == 3 && rcnt >= 3000) && n < 30000) begin @(posedge clk); n++; end
    check("e_reached_read", rcnt >= 3000, 1);
    #2 arst = 1;
    #1;
    check("e_reset_now", {busy, we, start, done, pass, tmo}, 6'b0);
    repeat (3) @(posedge clk);
    #2 arst = 0;
    repeat (5) @(posedge clk);
    check("e_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    launch(0);
    wait_done(d0, 20000);
    check("e_done_once", done_cnt - d0, 1);
    check("e_rd_strobes", rcnt, Total);
    check("e_pass", pass, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
